// File: rtl/sntc_ldpc_pkg.sv
// Shared types and default sizing for the LDPC syndrome iteration controller.
package sntc_ldpc_pkg;

  localparam int SNTC_MM       = 'h000a8;
  localparam int SNTC_NN       = 'h000d0;
  localparam int SNTC_SYN_LAT  = 2;
  localparam int SNTC_MAX_ITER = 8;
  // Latency counter width; SYN_LAT is limited to 1..15.
  localparam int SNTC_LATW     = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_EVAL,
    ST_FLIP,
    ST_DONE
  } syn_ctrl_state_e;

endpackage

// File: rtl/sntc_popcount.sv
// Combinational population count built as a balanced adder tree.
module sntc_popcount #(
  parameter int W = 8
) (
  input  logic [W-1:0]             bits,
  output logic [$clog2(W+1)-1:0]   count
);

  localparam int OW = $clog2(W + 1);
  localparam int LV = (W > 1) ? $clog2(W) : 0;
  localparam int NL = 1 << LV;

  genvar gi, gj;
  generate
    // Level 0 holds the (zero-padded) leaves; each later level halves the node count.
    for (gi = 0; gi <= LV; gi++) begin : g_lvl
      logic [OW-1:0] s [NL >> gi];
      if (gi == 0) begin : g_leaf
        for (gj = 0; gj < NL; gj++) begin : g_bit
          if (gj < W) begin : g_used
            assign s[gj] = OW'(bits[gj]);
          end else begin : g_pad
            assign s[gj] = '0;
          end
        end
      end else begin : g_add
        for (gj = 0; gj < (NL >> gi); gj++) begin : g_node
          assign s[gj] = g_lvl[gi-1].s[2*gj] + g_lvl[gi-1].s[2*gj+1];
        end
      end
    end
  endgenerate

  assign count = g_lvl[LV].s[0];

endmodule

// File: rtl/sntc_ldpc_syn_iter_ctrl.sv
// Sequences the syndrome unit and flip engine of the bit-flipping LDPC decoder:
// check, flip, re-check until the word is valid or the iteration budget runs out.
module sntc_ldpc_syn_iter_ctrl
  import sntc_ldpc_pkg::*;
#(
  parameter int MM       = SNTC_MM,
  parameter int NN       = SNTC_NN,
  parameter int SUM_MM   = $clog2(MM + 1),
  parameter int SYN_LAT  = SNTC_SYN_LAT,
  parameter int MAX_ITER = SNTC_MAX_ITER,
  parameter int ITW      = $clog2(MAX_ITER + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NN-1:0]     in_cw,
  output logic [NN-1:0]     syn_y,
  output logic              syn_clr,
  input  logic [MM-1:0]     syn_vec,
  input  logic              syn_valid_cword,
  output logic              flip_req,
  output logic [MM-1:0]     flip_syn,
  input  logic              flip_ack,
  input  logic [NN-1:0]     flip_cw,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NN-1:0]     out_cw,
  output logic              out_ok,
  output logic [ITW-1:0]    out_iter,
  output logic [SUM_MM-1:0] out_wt,
  input  logic              abort
);

  localparam int LATW = SNTC_LATW;
  localparam int PCW  = $clog2(MM + 1);

  syn_ctrl_state_e state, state_next;

  logic [NN-1:0]     cw_q;
  logic [ITW-1:0]    iter;
  logic [LATW-1:0]   lat_cnt;
  logic [MM-1:0]     syn_q;
  logic [SUM_MM-1:0] wt_q;
  logic              ok_q;
  logic              clr_q;
  logic [PCW-1:0]    wt_now;

  logic load_in, load_flip, at_max;

  sntc_popcount #(.W(MM)) u_popcount (
    .bits  (syn_vec),
    .count (wt_now)
  );

  // abort wins over every handshake, so the loads are qualified with it.
  assign load_in   = (state == ST_IDLE) && in_valid && !abort;
  assign load_flip = (state == ST_FLIP) && flip_ack && !abort;
  assign at_max    = (iter == ITW'(MAX_ITER));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) state_next = ST_WAIT;
        ST_WAIT: if (lat_cnt == '0) state_next = ST_EVAL;
        ST_EVAL: state_next = (syn_valid_cword || at_max) ? ST_DONE : ST_FLIP;
        ST_FLIP: if (flip_ack) state_next = ST_WAIT;
        ST_DONE: if (out_ready) state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == ST_IDLE);
    flip_req  = (state == ST_FLIP);
    out_valid = (state == ST_DONE);
    syn_clr   = (state == ST_WAIT) && clr_q;
  end

  // clr_q marks the first WAIT cycle of each check, whether entered from IDLE or FLIP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cw_q    <= '0;
      iter    <= '0;
      lat_cnt <= '0;
      syn_q   <= '0;
      wt_q    <= '0;
      ok_q    <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      clr_q <= 1'b0;
      if (load_in) begin
        cw_q    <= in_cw;
        iter    <= '0;
        lat_cnt <= LATW'(SYN_LAT - 1);
        clr_q   <= 1'b1;
      end
      if (load_flip) begin
        cw_q    <= flip_cw;
        iter    <= iter + ITW'(1);
        lat_cnt <= LATW'(SYN_LAT - 1);
        clr_q   <= 1'b1;
      end
      if (state == ST_WAIT && !abort && lat_cnt != '0) begin
        lat_cnt <= lat_cnt - LATW'(1);
      end
      if (state == ST_EVAL && !abort) begin
        wt_q  <= SUM_MM'(wt_now);
        syn_q <= syn_vec;
        ok_q  <= syn_valid_cword;
      end
    end
  end

  assign syn_y    = cw_q;
  assign flip_syn = syn_q;
  assign out_cw   = cw_q;
  assign out_ok   = ok_q;
  assign out_iter = iter;
  assign out_wt   = wt_q;

endmodule

// File: tb/tb_sntc_ldpc_syn_iter_ctrl.sv
// Randomized scoreboard bench for the syndrome iteration controller with a
// behavioural syndrome unit (random parity checks) and flip-engine responder.
module tb_sntc_ldpc_syn_iter_ctrl;

  localparam int MM       = 20;
  localparam int NN       = 32;
  localparam int SYN_LAT  = 2;
  localparam int MAX_ITER = 3;
  localparam int SUM_MM   = $clog2(MM + 1);
  localparam int ITW      = $clog2(MAX_ITER + 1);

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, syn_clr, syn_valid_cword;
  logic flip_req, flip_ack, out_valid, out_ready, out_ok, abort;
  logic [NN-1:0] in_cw, syn_y, flip_cw, out_cw;
  logic [MM-1:0] syn_vec, flip_syn;
  logic [ITW-1:0] out_iter;
  logic [SUM_MM-1:0] out_wt;

  always #5 clk = ~clk;

  sntc_ldpc_syn_iter_ctrl #(
    .MM(MM), .NN(NN), .SUM_MM(SUM_MM), .SYN_LAT(SYN_LAT),
    .MAX_ITER(MAX_ITER), .ITW(ITW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_cw(in_cw),
    .syn_y(syn_y), .syn_clr(syn_clr), .syn_vec(syn_vec),
    .syn_valid_cword(syn_valid_cword),
    .flip_req(flip_req), .flip_syn(flip_syn), .flip_ack(flip_ack), .flip_cw(flip_cw),
    .out_valid(out_valid), .out_ready(out_ready), .out_cw(out_cw), .out_ok(out_ok),
    .out_iter(out_iter), .out_wt(out_wt), .abort(abort)
  );

  typedef struct {
    logic [NN-1:0] cw;
    logic          ok;
    int            iter;
    int            wt;
  } res_t;

  res_t          exp_q[$];
  logic [MM-1:0] fsyn_q[$];
  logic [NN-1:0] fcw_q[$];
  logic [NN-1:0] mask [MM];
  int checks = 0;
  int passes = 0;
  bit abort_req = 1'b0;
  bit abort_done;

  function automatic void check(string nm, longint unsigned act, longint unsigned expv);
    checks++;
    if (act == expv) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
  endfunction

  task automatic finish_run();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  endtask

  function automatic logic [MM-1:0] syn_of(input logic [NN-1:0] cw);
    logic [MM-1:0] s;
    for (int i = 0; i < MM; i++) s[i] = ^(cw & mask[i]);
    return s;
  endfunction

  // Syndrome unit: output reflects syn_y from SYN_LAT cycles earlier.
  logic [MM-1:0] pipe [SYN_LAT];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYN_LAT; k++) pipe[k] <= '0;
    end else begin
      pipe[0] <= syn_of(syn_y);
      for (int k = 1; k < SYN_LAT; k++) pipe[k] <= pipe[k-1];
    end
  end
  assign syn_vec = pipe[SYN_LAT-1];
  assign syn_valid_cword = (syn_vec == '0);

  // Decoder behaviour: flip word number conv_at is a true codeword (all zero).
  task automatic model(input logic [NN-1:0] cw_in, input int conv_at);
    logic [NN-1:0] cw, fw;
    logic [MM-1:0] s;
    int it;
    res_t r;
    cw = cw_in;
    it = 0;
    forever begin
      s = syn_of(cw);
      if (s == '0) begin r.ok = 1'b1; break; end
      if (it == MAX_ITER) begin r.ok = 1'b0; break; end
      fw = (it == conv_at) ? '0 : NN'($urandom);
      fsyn_q.push_back(s);
      fcw_q.push_back(fw);
      cw = fw;
      it++;
    end
    r.cw = cw;
    r.iter = it;
    r.wt = $countones(s);
    exp_q.push_back(r);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready) begin
      @(negedge clk);
      n++;
      if (n > 500) begin check("in_ready_timeout", 0, 1); finish_run(); end
    end
  endtask

  // Called right after a negedge; returns at the negedge of the cycle after acceptance.
  task automatic send(input logic [NN-1:0] cw, input bit use_model, input int conv_at);
    wait_ready();
    in_valid = 1'b1;
    in_cw = cw;
    if (use_model) model(cw, conv_at);
    @(negedge clk);
    in_valid = 1'b0;
    in_cw = NN'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 || !in_ready) begin
      @(negedge clk);
      n++;
      if (n > 3000) begin check("drain_timeout", 0, 1); finish_run(); end
    end
  endtask

  // Flip engine: checks the handed-over syndrome, acks after 0..2 cycles.
  initial begin
    logic [MM-1:0] es;
    logic [NN-1:0] w;
    int d;
    flip_ack = 1'b0;
    flip_cw = '0;
    abort = 1'b0;
    abort_done = 1'b0;
    forever begin
      @(negedge clk);
      flip_ack = 1'b0;
      if (flip_req) begin
        if (abort_req && !abort_done) begin
          flip_ack = 1'b1;
          flip_cw = NN'($urandom);
          abort = 1'b1;
          @(negedge clk);
          flip_ack = 1'b0;
          abort = 1'b0;
          abort_done = 1'b1;
        end else begin
          es = '0;
          w = '0;
          if (fsyn_q.size() == 0 || fcw_q.size() == 0) check("unexpected_flip_req", 1, 0);
          else begin es = fsyn_q.pop_front(); w = fcw_q.pop_front(); end
          check("flip_syn", flip_syn, es);
          d = int'($urandom_range(0, 2));
          repeat (d) begin
            @(negedge clk);
            check("flip_req_held", flip_req, 1);
            check("flip_syn_held", flip_syn, es);
          end
          flip_ack = 1'b1;
          flip_cw = w;
          @(negedge clk);
          flip_ack = 1'b0;
          flip_cw = NN'($urandom);
        end
      end else if ($urandom_range(0, 7) == 0) begin
        flip_ack = 1'b1;
        flip_cw = NN'($urandom);
      end
    end
  end

  // Result monitor: the second result is held off for 10 cycles.
  initial begin
    res_t e;
    int hold, ntx;
    bit seen;
    out_ready = 1'b0;
    ntx = 0;
    seen = 1'b0;
    hold = 0;
    forever begin
      @(negedge clk);
      if (out_ready) begin
        out_ready = 1'b0;
        seen = 1'b0;
        check("in_ready_after_out", in_ready, 1);
        check("out_valid_dropped", out_valid, 0);
      end else if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
          out_ready = 1'b1;
        end else begin
          if (!seen) begin
            seen = 1'b1;
            hold = (ntx == 1) ? 10 : int'($urandom_range(0, 2));
          end
          e = exp_q[0];
          if (hold > 0) begin
            hold--;
            check("held_out_cw", out_cw, e.cw);
            check("held_out_wt", out_wt, e.wt);
            check("held_in_ready", in_ready, 0);
          end else begin
            e = exp_q.pop_front();
            check("out_cw", out_cw, e.cw);
            check("out_ok", out_ok, e.ok);
            check("out_iter", out_iter, e.iter);
            check("out_wt", out_wt, e.wt);
            $display("txn %0d: cw=%h ok=%0d iter=%0d wt=%0d", ntx, out_cw, out_ok, out_iter, out_wt);
            ntx++;
            out_ready = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    check("global_timeout", 0, 1);
    finish_run();
  end

  initial begin
    logic [NN-1:0] cwa;
    int n;
    bit bad;
    rst = 1'b1;
    in_valid = 1'b0;
    in_cw = '0;
    for (int i = 0; i < MM; i++) mask[i] = NN'($urandom);
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_syn_y", syn_y, 0);
    check("rst_syn_clr", syn_clr, 0);
    check("rst_flip_req", flip_req, 0);
    check("rst_flip_syn", flip_syn, 0);
    check("rst_payload", {out_cw, out_ok, out_iter, out_wt}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Zero codeword: one clear pulse, result four cycles after acceptance.
    send('0, 1'b1, -1);
    check("zero_syn_clr_first", syn_clr, 1);
    check("zero_in_ready_busy", in_ready, 0);
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      check("zero_syn_clr_once", syn_clr, 0);
      check("zero_out_valid_time", out_valid, (k == 4) ? 1 : 0);
    end

    send(NN'($urandom) | 1, 1'b1, 1);   // two flips to converge, backpressured
    send(NN'($urandom) | 1, 1'b1, -1);  // never converges
    drain();

    // Abort in the same cycle as the flip acknowledge.
    cwa = NN'($urandom) | 1;
    abort_req = 1'b1;
    send(cwa, 1'b0, -1);
    n = 0;
    forever begin
      @(negedge clk);
      #1;
      if (abort_done) break;
      n++;
      if (n > 100) begin check("abort_timeout", 0, 1); finish_run(); end
    end
    check("abort_in_ready", in_ready, 1);
    check("abort_flip_req", flip_req, 0);
    check("abort_cw_kept", syn_y, cwa);
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid || flip_req || syn_clr) bad = 1'b1;
    end
    check("abort_quiet", bad, 0);
    send(NN'($urandom) | 1, 1'b1, 0);
    drain();

    // Asynchronous reset in the middle of WAIT.
    send(NN'($urandom) | 1, 1'b0, -1);
    #2 rst = 1'b1;
    #1;
    check("arst_in_ready", in_ready, 1);
    check("arst_syn_y", syn_y, 0);
    check("arst_syn_clr", syn_clr, 0);
    check("arst_outs", {out_valid, flip_req, flip_syn}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("arst_in_ready_after", in_ready, 1);
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid || flip_req) bad = 1'b1;
    end
    check("arst_word_discarded", bad, 0);

    for (int t = 0; t < 25; t++) begin
      send(($urandom_range(0, 4) == 0) ? '0 : NN'($urandom), 1'b1,
           int'($urandom_range(0, 4)) - 1);
    end
    drain();
    repeat (3) @(negedge clk);
    check("flip_queue_empty", fsyn_q.size(), 0);
    finish_run();
  end

endmodule
